dmux_ce_xfer: RTL and testbench

- Parametrised, buffered successor to the toggle-request data distributor.
- Moves valid-tagged multi-bit words from a full-rate producer to a consumer that samples only on a clock-enable strobe `ce_slow`. Both sides run on one clock.
- Adds an input FIFO with ready backpressure, configurable synchroniser depth, a toggle request/acknowledge loop so no word is overwritten in flight, and overflow reporting.

---
 rtl/dmux_ce_xfer.sv | 137 +++++++++++++
 tb/tb_dmux_ce_xfer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmux_ce_xfer.sv
// Buffered word transfer from a full-rate producer to a ce_slow-gated consumer.
// Words are queued in a FIFO and handed over with a toggle req/ack loop.
module dmux_ce_xfer #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int SYNC_STG = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce_slow,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     data_in_valid,
    output logic                     data_in_ready,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_out_valid,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  full, empty, push, pop;

    state_t                state_q;
    logic [DATA_W-1:0]     hold_q;
    logic                  req_tgl_q;

    logic [SYNC_STG+1:0]   sreg_q;
    logic                  slow_edge, ack_tgl;
    logic [SYNC_STG-1:0]   ack_sync_q;
    logic                  ack_sync, ack_match;

    logic [DATA_W-1:0]     data_out_q;
    logic                  data_out_valid_q;
    logic                  overflow_q;

    // Full/empty come from the registered count only, so a same-cycle pop
    // never lets a write into a full FIFO.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push      = data_in_valid & ~full;
    assign ack_match = (ack_sync == req_tgl_q);

    always_comb begin
        pop = 1'b0;
        case (state_q)
            IDLE:    pop = ~empty;
            BUSY:    pop = ack_match & ~empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Hold register only changes on a pop, so it is stable while a
    // toggle is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            req_tgl_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (!empty) state_q <= BUSY;
                BUSY: if (ack_match && empty) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (pop) begin
                hold_q    <= mem_q[rd_ptr_q];
                req_tgl_q <= ~req_tgl_q;
            end
        end
    end

    // Slow side: sreg_q[0] re-times req_tgl, the rest form the synchroniser.
    assign slow_edge = sreg_q[SYNC_STG] ^ sreg_q[SYNC_STG+1];
    assign ack_tgl   = sreg_q[SYNC_STG+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q           <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else if (ce_slow) begin
            sreg_q           <= {sreg_q[SYNC_STG:0], req_tgl_q};
            data_out_valid_q <= slow_edge;
            if (slow_edge)
                data_out_q <= hold_q;
        end
    end

    assign ack_sync = ack_sync_q[SYNC_STG-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STG-2:0], ack_tgl};
            overflow_q <= data_in_valid & full;
        end
    end

    assign data_in_ready  = ~full;
    assign fifo_level     = count_q;
    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_dmux_ce_xfer.sv
// Directed bench for dmux_ce_xfer (DATA_W=8, DEPTH=4, SYNC_STG=2).
module tb_dmux_ce_xfer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce_slow = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic [2:0] fifo_level;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    dmux_ce_xfer #(.DATA_W(8), .DEPTH(4), .SYNC_STG(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ce_slow        (ce_slow),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .fifo_level     (fifo_level),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        settle(3);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_dout k=%0d got=%h exp=00", k, data_out); end
            total++; if (data_out_valid !== 1'b0) begin bad++; $display("FAIL reset_dvalid k=%0d got=%b exp=0", k, data_out_valid); end
            total++; if (data_in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready k=%0d got=%b exp=1", k, data_in_ready); end
            total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level k=%0d got=%0d exp=0", k, fifo_level); end
            total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf k=%0d got=%b exp=0", k, overflow); end
        end
    endtask

    // One word accepted at E0 must show up as a one-cycle strobe after E5.
    task automatic test_latency(input logic [7:0] w);
        data_in = w;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            total++;
            if (data_out_valid !== (k == 5)) begin
                bad++; $display("FAIL lat_valid w=%h k=%0d got=%b exp=%b", w, k, data_out_valid, (k == 5));
            end
            if (k >= 5) begin
                total++;
                if (data_out !== w) begin bad++; $display("FAIL lat_data w=%h k=%0d got=%h exp=%h", w, k, data_out, w); end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic       exp_v;
        logic [7:0] exp_d;
        logic [2:0] exp_lvl [6];
        exp_lvl[0] = 3'd1; exp_lvl[1] = 3'd1; exp_lvl[2] = 3'd2;
        exp_lvl[3] = 3'd3; exp_lvl[4] = 3'd4; exp_lvl[5] = 3'd4;
        ce_slow = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            data_in_valid = (k < 6);
            data_in = 8'(k + 1);
            tick();
            exp_v = (k >= 5) && (k <= 33) && ((k - 5) % 7 == 0);
            exp_d = 8'((k - 5) / 7 + 1);
            total++;
            if (data_out_valid !== exp_v) begin bad++; $display("FAIL b2b_valid k=%0d got=%b exp=%b", k, data_out_valid, exp_v); end
            if (exp_v) begin
                total++;
                if (data_out !== exp_d) begin bad++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, data_out, exp_d); end
            end
            total++;
            if (overflow !== (k == 5)) begin bad++; $display("FAIL b2b_ovf k=%0d got=%b exp=%b", k, overflow, (k == 5)); end
            if (k <= 5) begin
                total++;
                if (fifo_level !== exp_lvl[k]) begin bad++; $display("FAIL b2b_level k=%0d got=%0d exp=%0d", k, fifo_level, exp_lvl[k]); end
            end
            if (k == 4 || k == 5) begin
                total++;
                if (data_in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready k=%0d got=%b exp=0", k, data_in_ready); end
            end
        end
        data_in_valid = 1'b0;
        total++;
        if (fifo_level !== 3'd0) begin bad++; $display("FAIL b2b_drained got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_slow_ce;
        int n_del = 0;
        int run   = 0;
        for (int k = 0; k < 200; k++) begin
            ce_slow = (k % 4 == 0);
            data_in_valid = (k < 3);
            data_in = 8'((k + 1) * 16);
            tick();
            if (data_out_valid) begin
                if (run == 0) begin
                    n_del++;
                    total++;
                    if (data_out !== 8'(n_del * 16)) begin bad++; $display("FAIL slow_data n=%0d got=%h exp=%h", n_del, data_out, 8'(n_del * 16)); end
                end
                run++;
            end else if (run != 0) begin
                total++;
                if (run != 4) begin bad++; $display("FAIL slow_width n=%0d got=%0d exp=4", n_del, run); end
                run = 0;
            end
        end
        data_in_valid = 1'b0;
        ce_slow = 1'b1;
        total++;
        if (n_del != 3) begin bad++; $display("FAIL slow_count got=%0d exp=3", n_del); end
    endtask

    // The first word moves into the hold register while ce_slow is low,
    // so five words are queued and the sixth is the one dropped.
    task automatic test_ce_stuck;
        int n_del = 0;
        ce_slow = 1'b0;
        for (int k = 0; k < 8; k++) begin
            data_in_valid = (k < 6);
            data_in = 8'(8'h41 + k);
            tick();
            total++;
            if (overflow !== (k == 5)) begin bad++; $display("FAIL stuck_ovf k=%0d got=%b exp=%b", k, overflow, (k == 5)); end
            total++;
            if (data_out_valid !== 1'b0) begin bad++; $display("FAIL stuck_valid k=%0d got=%b exp=0", k, data_out_valid); end
            if (k >= 4) begin
                total++;
                if (fifo_level !== 3'd4) begin bad++; $display("FAIL stuck_level k=%0d got=%0d exp=4", k, fifo_level); end
                total++;
                if (data_in_ready !== 1'b0) begin bad++; $display("FAIL stuck_ready k=%0d got=%b exp=0", k, data_in_ready); end
            end
        end
        data_in_valid = 1'b0;
        ce_slow = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (data_out_valid) begin
                total++;
                if (data_out !== 8'(8'h41 + n_del)) begin bad++; $display("FAIL stuck_order n=%0d got=%h exp=%h", n_del, data_out, 8'(8'h41 + n_del)); end
                n_del++;
            end
        end
        total++;
        if (n_del != 5) begin bad++; $display("FAIL stuck_count got=%0d exp=5", n_del); end
        total++;
        if (fifo_level !== 3'd0) begin bad++; $display("FAIL stuck_drain got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_reset_busy;
        ce_slow = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data_in_valid = 1'b1;
            data_in = 8'(8'h51 + k);
            tick();
        end
        data_in_valid = 1'b0;
        total++;
        if (fifo_level !== 3'd3) begin bad++; $display("FAIL rbusy_queued got=%0d exp=3", fifo_level); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rbusy_dout got=%h exp=00", data_out); end
        total++; if (data_out_valid !== 1'b0) begin bad++; $display("FAIL rbusy_dvalid got=%b exp=0", data_out_valid); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rbusy_level got=%0d exp=0", fifo_level); end
        total++; if (data_in_ready !== 1'b1) begin bad++; $display("FAIL rbusy_ready got=%b exp=1", data_in_ready); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rbusy_ovf got=%b exp=0", overflow); end
        settle(2);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            total++;
            if (data_out_valid !== 1'b0 || data_out !== 8'h00) begin
                bad++; $display("FAIL rbusy_spurious k=%0d got=%b/%h exp=0/00", k, data_out_valid, data_out);
            end
        end
        test_latency(8'h3C);
    endtask

    initial begin
        test_reset();
        test_latency(8'hA5);
        settle(10);
        test_back_to_back();
        settle(10);
        test_slow_ce();
        settle(10);
        test_ce_stuck();
        settle(10);
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
